// File: rtl/main_loader.sv
// Serial-to-parallel operand loader: gathers four words over a valid/ready stream,
// pulses reg_en so the register bank captures them together, then waits for release.
module main_loader #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             i_release,
    input  logic             abort,
    output logic [WIDTH-1:0] num1,
    output logic [WIDTH-1:0] num2,
    output logic [WIDTH-1:0] num3,
    output logic [WIDTH-1:0] num4,
    output logic             reg_en,
    output logic             reg_clr,
    output logic             frame_done,
    output logic [1:0]       word_cnt
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_LOAD    = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_word_cnt;
    logic [WIDTH-1:0] r_num1;
    logic [WIDTH-1:0] r_num2;
    logic [WIDTH-1:0] r_num3;
    logic [WIDTH-1:0] r_num4;
    logic             r_reg_en;
    logic             r_reg_clr;
    logic             r_frame_done;
    logic             w_in_ready;
    logic             w_xfer;

    // rst is included so the stream is stalled while the block is held in reset
    assign w_in_ready = (r_state == ST_COLLECT) && !abort && rst;
    assign w_xfer     = in_valid && w_in_ready;

    // Next-state decode; abort overrides every state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_COLLECT: begin
                if (w_xfer && (r_word_cnt == 2'd3)) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_COLLECT;
                end
            end
            ST_LOAD: w_next_state = ST_HOLD;
            ST_HOLD: begin
                if (i_release) begin
                    w_next_state = ST_COLLECT;
                end else begin
                    w_next_state = ST_HOLD;
                end
            end
            default: w_next_state = ST_COLLECT;
        endcase
        if (abort) begin
            w_next_state = ST_COLLECT;
        end else begin
            w_next_state = w_next_state;
        end
    end

    // State register and registered control pulses, decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_COLLECT;
            r_reg_en     <= 1'b0;
            r_reg_clr    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_reg_en     <= (w_next_state == ST_LOAD);
            r_reg_clr    <= abort;
            r_frame_done <= (w_next_state == ST_HOLD);
        end
    end

    // Shadow slots and fill index; slots not written keep the previous frame's word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_cnt <= 2'd0;
            r_num1     <= {WIDTH{1'b0}};
            r_num2     <= {WIDTH{1'b0}};
            r_num3     <= {WIDTH{1'b0}};
            r_num4     <= {WIDTH{1'b0}};
        end else if (abort) begin
            r_word_cnt <= 2'd0;
            r_num1     <= {WIDTH{1'b0}};
            r_num2     <= {WIDTH{1'b0}};
            r_num3     <= {WIDTH{1'b0}};
            r_num4     <= {WIDTH{1'b0}};
        end else if (w_xfer) begin
            case (r_word_cnt)
                2'd0:    r_num1 <= in_data;
                2'd1:    r_num2 <= in_data;
                2'd2:    r_num3 <= in_data;
                2'd3:    r_num4 <= in_data;
                default: r_num1 <= in_data;
            endcase
            r_word_cnt <= r_word_cnt + 2'd1;
        end else begin
            r_word_cnt <= r_word_cnt;
        end
    end

    assign in_ready   = w_in_ready;
    assign num1       = r_num1;
    assign num2       = r_num2;
    assign num3       = r_num3;
    assign num4       = r_num4;
    assign reg_en     = r_reg_en;
    assign reg_clr    = r_reg_clr;
    assign frame_done = r_frame_done;
    assign word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_main_loader.sv
// Directed bench for main_loader: a per-cycle vector table plus hand-written
// sequences for asynchronous reset in the middle of a frame.
module tb_main_loader;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             i_release;
    logic             abort;
    logic [WIDTH-1:0] num1, num2, num3, num4;
    logic             reg_en, reg_clr, frame_done;
    logic [1:0]       word_cnt;

    int checks   = 0;
    int failures = 0;

    main_loader #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .i_release  (i_release),
        .abort      (abort),
        .num1       (num1),
        .num2       (num2),
        .num3       (num3),
        .num4       (num4),
        .reg_en     (reg_en),
        .reg_clr    (reg_clr),
        .frame_done (frame_done),
        .word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus: inputs, in_ready before the edge, registered outputs after it.
    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        rel;
        logic        ab;
        logic        rdy;
        logic [1:0]  cnt;
        logic        en;
        logic        clr;
        logic        done;
        logic [31:0] n1, n2, n3, n4;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [31:0] d, input logic rel, input logic ab,
                       input logic rdy, input logic [1:0] cnt, input logic en, input logic clr,
                       input logic done, input logic [31:0] n1, input logic [31:0] n2,
                       input logic [31:0] n3, input logic [31:0] n4);
        vec_t t;
        t.v = v; t.d = d; t.rel = rel; t.ab = ab; t.rdy = rdy; t.cnt = cnt;
        t.en = en; t.clr = clr; t.done = done; t.n1 = n1; t.n2 = n2; t.n3 = n3; t.n4 = n4;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] cnt, input logic en,
                            input logic clr, input logic done, input logic [31:0] n1,
                            input logic [31:0] n2, input logic [31:0] n3, input logic [31:0] n4);
        chk({tag, ".word_cnt"},   {30'd0, word_cnt},   {30'd0, cnt});
        chk({tag, ".reg_en"},     {31'd0, reg_en},     {31'd0, en});
        chk({tag, ".reg_clr"},    {31'd0, reg_clr},    {31'd0, clr});
        chk({tag, ".frame_done"}, {31'd0, frame_done}, {31'd0, done});
        chk({tag, ".num1"}, num1, n1);
        chk({tag, ".num2"}, num2, n2);
        chk({tag, ".num3"}, num3, n3);
        chk({tag, ".num4"}, num4, n4);
    endtask

    int en_seen;

    initial begin
        // Basic frame with in_valid held high, then LOAD/HOLD and release
        add(1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h11, 32'h0, 32'h0, 32'h0);
        add(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h11, 32'h22, 32'h0, 32'h0);
        add(1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 32'h11, 32'h22, 32'h33, 32'h0);
        add(1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44);
        add(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44);
        add(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44);
        add(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44);
        // Frame with valid gaps: valid on cycles 0, 3, 4, 9
        add(1'b1, 32'h111, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h111, 32'h22, 32'h33, 32'h44);
        for (int i = 0; i < 2; i++)
            add(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h111, 32'h22, 32'h33, 32'h44);
        add(1'b1, 32'h222, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h111, 32'h222, 32'h33, 32'h44);
        add(1'b1, 32'h333, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 32'h111, 32'h222, 32'h333, 32'h44);
        for (int i = 0; i < 4; i++)
            add(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 32'h111, 32'h222, 32'h333, 32'h44);
        add(1'b1, 32'h444, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h111, 32'h222, 32'h333, 32'h444);
        add(1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 32'h111, 32'h222, 32'h333, 32'h444);
        // HOLD with a pending word, then release; the word lands in num1
        for (int i = 0; i < 5; i++)
            add(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 32'h111, 32'h222, 32'h333, 32'h444);
        add(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h111, 32'h222, 32'h333, 32'h444);
        add(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h222, 32'h333, 32'h444);
        // Two more words, then abort with a pending word 0xC
        add(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'hA, 32'h333, 32'h444);
        add(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'hA, 32'hB, 32'h444);
        add(1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        add(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'hC, 32'h0, 32'h0, 32'h0);
        add(1'b1, 32'hD, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'hC, 32'hD, 32'h0, 32'h0);
        add(1'b1, 32'hE, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 32'hC, 32'hD, 32'hE, 32'h0);
        add(1'b1, 32'hF, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 32'hC, 32'hD, 32'hE, 32'hF);
        // Abort during LOAD: the pulse already issued stands, clear follows
        add(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        add(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        // Abort held two edges gives two clear cycles
        for (int i = 0; i < 2; i++)
            add(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        add(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        // Abort together with release in HOLD
        add(1'b1, 32'h1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0, 32'h0, 32'h0);
        add(1'b1, 32'h2, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h1, 32'h2, 32'h0, 32'h0);
        add(1'b1, 32'h3, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 32'h1, 32'h2, 32'h3, 32'h0);
        add(1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h1, 32'h2, 32'h3, 32'h4);
        add(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 32'h1, 32'h2, 32'h3, 32'h4);
        add(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        add(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Reset with a word offered: in_ready must stay low
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h99; i_release = 1'b0; abort = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("reset.in_ready", {31'd0, in_ready}, 32'd0);
        chk_outs("reset", 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        in_valid = 1'b0;
        #20 rst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            in_valid  = vecs[i].v;
            in_data   = vecs[i].d;
            i_release = vecs[i].rel;
            abort     = vecs[i].ab;
            #2;
            chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].rdy});
            @(posedge clk); #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].en, vecs[i].clr, vecs[i].done,
                     vecs[i].n1, vecs[i].n2, vecs[i].n3, vecs[i].n4);
        end
        in_valid = 1'b0; i_release = 1'b0; abort = 1'b0;

        // Three words, then asynchronous reset mid-cycle
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h31 + i;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre_rst.word_cnt", {30'd0, word_cnt}, 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("async_rst.in_ready", {31'd0, in_ready}, 32'd0);
        chk_outs("async_rst", 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // Fresh frame after reset: first word in num1, single reg_en pulse
        en_seen = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'h41 + i;
            @(posedge clk); #1;
            if (i == 0) chk("post_rst.num1_first", num1, 32'h41);
            if (reg_en) en_seen++;
        end
        in_valid = 1'b0;
        chk("post_rst.reg_en_after_4th", {31'd0, reg_en}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (reg_en) en_seen++;
        end
        chk("post_rst.reg_en_pulses", en_seen, 32'd1);
        chk_outs("post_rst", 2'd0, 1'b0, 1'b0, 1'b1, 32'h41, 32'h42, 32'h43, 32'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/main_loader.md
Name: main_loader

Overview:
- Write-side front end for the main register bank: collects four operands arriving one per handshake on a serial valid/ready stream.
- Presents the four operands in parallel on num1..num4 and issues a one-cycle load-enable pulse, so the bank captures all four in the same edge.
- Holds off further input until the datapath controller releases the frame. Supports synchronous abort with a clear pulse toward the bank.

Parameters:
- WIDTH, 32, width of each operand word and each parallel output.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word valid.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  loader can accept a word this cycle.
- release  input  1  controller has consumed the loaded frame; sampled only in HOLD.
- abort  input  1  synchronous frame abort, any state.
- num1, num2, num3, num4  output  WIDTH each  parallel operands to the register bank.
- reg_en  output  1  one-cycle load pulse to the bank's enable.
- reg_clr  output  1  one-cycle clear pulse to the bank's clear.
- frame_done  output  1  frame loaded and awaiting release.
- word_cnt  output  2  index of the next slot to fill (0..3).

Behaviour:
- Reset (rst low, asynchronous):
  - state = COLLECT; word_cnt = 0; num1..num4 = 0.
  - reg_en, reg_clr and frame_done are all 0.
  - in_ready is forced 0 while rst is low.
- in_ready = (state == COLLECT) && !abort && rst. It is combinational, with no dependency on in_valid.
- Transfer occurs on a rising edge where in_valid && in_ready. Data written to slot word_cnt: 0→num1, 1→num2, 2→num3, 3→num4. word_cnt then increments.
- in_valid with in_ready low: no transfer. Upstream holds in_data; nothing is dropped.
- State COLLECT:
  - Transfer with word_cnt < 3 → stay in COLLECT.
  - Transfer with word_cnt == 3 → LOAD; word_cnt wraps to 0.
- State LOAD (exactly one cycle):
  - reg_en = 1; in_ready = 0; num1..num4 stable.
  - → HOLD.
- State HOLD:
  - frame_done = 1; in_ready = 0; num1..num4 stable.
  - release high → COLLECT next cycle, and frame_done drops that cycle.
  - release ignored outside HOLD.
- Latency:
  - 4th transfer at edge E → reg_en high during cycle E..E+1.
  - Bank captures at edge E+1.
  - frame_done high from E+1 until the edge after release.
- reg_en, frame_done and reg_clr are registered outputs: state-decoded from flops, no combinational path from inputs.
- Slot behaviour during COLLECT: num outputs are the shadow slots and change as words arrive. The bank ignores them because reg_en is low. Unfilled slots keep their previous frame's values.
- Abort (synchronous, highest priority):
  - Edge with abort high, in any state → next state COLLECT, word_cnt = 0, num1..num4 = 0.
  - reg_clr = 1 for the cycle following that edge.
  - Abort held for N edges → reg_clr high for N cycles.
- Simultaneous events:
  - abort + in_valid in COLLECT: in_ready is 0, so no transfer; the word stays pending upstream.
  - abort in LOAD: reg_en still pulses in the current cycle (already registered). reg_clr follows one cycle later, so the bank ends cleared.
  - abort + release in HOLD: abort wins; outcome identical, plus reg_clr.
- Reset mid-frame: all state discarded asynchronously. The first word after rst rises goes to num1.
- No arithmetic. Words pass bit-exact; WIDTH applies to all data paths.

Test Plan:
- Reset, then stream 0x00000011, 0x00000022, 0x00000033, 0x00000044 with in_valid held high:
  - num1..num4 = 0x11, 0x22, 0x33, 0x44.
  - reg_en high exactly one cycle, the cycle after the 4th transfer.
  - frame_done high from the next cycle; in_ready low throughout LOAD/HOLD.
- Same frame with in_valid gaps (valid high on cycles 0, 3, 4, 9):
  - word_cnt steps 1, 2, 3, 0 only on transfer edges.
  - reg_en only after the cycle-9 transfer.
- In HOLD, keep in_valid=1 with 0xDEADBEEF for 5 cycles, then release=1 for one cycle:
  - No transfer during HOLD.
  - in_ready rises the cycle after release; 0xDEADBEEF lands in num1.
- Send 2 words (0xA, 0xB), then abort=1 for one cycle with in_valid=1 and data 0xC:
  - 0xC is not accepted; num1..num4 = 0; word_cnt = 0.
  - reg_clr high exactly one cycle.
  - 0xC is accepted next cycle into num1.
- Drive rst low asynchronously (mid-cycle) after 3 words:
  - All outputs go to reset values immediately, without waiting for clk.
  - After release of rst, a full new 4-word frame loads correctly with a single reg_en pulse.
